settable_clock_core: RTL and testbench
======================================

Name: settable_clock_core

Overview:
- Self-contained time-of-day core with a built-in 1 Hz prescaler and a user set-mode state machine.
- Driven by the three debounced button levels: increment, decrement and config.
- Outputs binary hours/minutes/seconds, the current mode, and per-field blank flags. These feed the seven-segment display driver, so the field being edited blinks.
- Replaces the fixed divider + counter pair, adding time setting, parametrised tick rate, hour modulus and blink rate.

Parameters:
- CLK_FREQ_HZ, 100_000_000: input clock frequency; prescaler period in cycles.
- HOURS_MODULO, 24: hour wrap value; legal values are 12 or 24 only. Any other value is an elaboration error.
- BLINK_HZ, 2: full on/off blink cycles per second for the selected field.

Ports:
- clk_100MHz_i, in, 1: system clock.
- reset_i, in, 1: asynchronous, active-high reset.
- inc_i, in, 1: debounced increment button level.
- dec_i, in, 1: debounced decrement button level.
- mode_i, in, 1: debounced config button level.
- seconds_o, out, 6: seconds, 0..59.
- minutes_o, out, 6: minutes, 0..59.
- hours_o, out, 5: hours, 0..HOURS_MODULO-1.
- mode_o, out, 2: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
- blank_o, out, 3: {hours, minutes, seconds} blank request to the display.
- second_tick_o, out, 1: one-cycle pulse on each counted second.

Behaviour:
- Reset (async assert, released synchronously by the user of the block):
  - seconds/minutes/hours = 0, mode = RUN, prescaler = 0, blink counter and phase = 0.
  - blank_o = 000, second_tick_o = 0.
  - Button history registers reset to 1, so a button held through reset release does NOT generate a press.
- Edge detection: press = level & ~level_q, evaluated per button each cycle. Any action takes effect on the clock edge where press is true; registered outputs show the new value one cycle after the input is first sampled high. A held button produces exactly one press.
- Prescaler and RUN mode:
  - Prescaler counts 0..CLK_FREQ_HZ-1 only in RUN.
  - At terminal count it wraps to 0, second_tick_o pulses for 1 cycle, and seconds increments.
  - Carry chain: seconds 59->0 increments minutes; minutes 59->0 increments hours; hours HOURS_MODULO-1 -> 0.
  - inc_i and dec_i are ignored in RUN.
- Mode FSM: a mode press advances RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - Entering SET_H clears the prescaler and holds it at 0 while in any SET state, so time is frozen.
  - Returning to RUN restarts counting from prescaler 0; the first tick comes CLK_FREQ_HZ cycles later.
- SET states:
  - An inc press adds 1 to the selected field and a dec press subtracts 1, each modulo that field's range.
  - Wrap examples: 59+1=0, 0-1=59, hours 23+1=0 and 0-1=23 (for 24). No carry or borrow into other fields.
  - second_tick_o stays 0.
- Simultaneous events:
  - inc and dec press in the same cycle: no change.
  - A mode press in the same cycle as inc/dec: the mode transition is taken and the adjust is discarded.
  - In RUN, a tick coinciding with a mode press: the tick's increment is applied and the FSM moves to SET_H.
- Blink:
  - Blink counter period = CLK_FREQ_HZ/(2*BLINK_HZ) cycles; the phase toggles at each wrap.
  - The counter free-runs in all modes and is cleared to 0 (phase 0) on every mode transition and on every adjust, so the edited field is immediately visible.
  - blank_o has the selected field's bit = phase (SET_H -> bit2, SET_M -> bit1, SET_S -> bit0); other bits 0. In RUN, blank_o = 000.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously, in any mode.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (CLK_FREQ_HZ=10, BLINK_HZ=1, HOURS_MODULO=24 unless stated):
- Reset then run 600 cycles:
  - second_tick_o pulses every 10 cycles, 60 pulses in total.
  - Time reads 00:01:00, mode_o=0, blank_o=000 throughout.
- Preload 23:59:59 via SET states, return to RUN, wait 10 cycles -> one tick, time 00:00:00.
- Mode press once -> mode_o=1, time frozen for 100 cycles, no ticks.
  - Five dec presses from 00 -> hours 19 (0,23,22,21,20,19).
  - blank_o[2] toggles every 5 cycles and is 0 right after each press.
- In SET_M (minutes=58):
  - inc+dec pressed in the same cycle -> minutes stays 58.
  - inc held 50 cycles -> minutes 59 (a single step).
  - mode+inc in the same cycle -> mode_o=3, minutes 59.
- HOURS_MODULO=12: hours at 11, one inc in SET_H -> 0.
  - In RUN from 11:59:59, one tick -> 00:00:00.
- Reset pulse while in SET_S with inc_i held high:
  - All outputs zero, mode_o=0.
  - After release, no press registers until inc_i falls and rises again.

Source files
------------

// File: rtl/settable_clock_core_if.sv
// Button levels in, binary time / mode / blank flags out for settable_clock_core.
interface settable_clock_core_if;
   logic       inc_i;
   logic       dec_i;
   logic       mode_i;
   logic [5:0] seconds_o;
   logic [5:0] minutes_o;
   logic [4:0] hours_o;
   logic [1:0] mode_o;
   logic [2:0] blank_o;
   logic       second_tick_o;

   modport master (
      output inc_i, dec_i, mode_i,
      input  seconds_o, minutes_o, hours_o, mode_o, blank_o, second_tick_o
   );

   modport slave (
      input  inc_i, dec_i, mode_i,
      output seconds_o, minutes_o, hours_o, mode_o, blank_o, second_tick_o
   );
endinterface

// File: rtl/settable_clock_core.sv
// Time-of-day core: 1 Hz prescaler, HH:MM:SS counters, button-driven set mode
// with a blinking blank request for the field being edited.
module settable_clock_core #(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned HOURS_MODULO = 24,
   parameter int unsigned BLINK_HZ     = 2
) (
   input logic                 clk_100MHz_i,
   input logic                 reset_i,
   settable_clock_core_if.slave io
);

   localparam int unsigned BLINK_PERIOD =
      (CLK_FREQ_HZ / (2 * BLINK_HZ) > 0) ? CLK_FREQ_HZ / (2 * BLINK_HZ) : 1;
   localparam int unsigned PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
   localparam logic [4:0]    HOUR_LAST  = 5'(HOURS_MODULO - 1);

   if (HOURS_MODULO != 12 && HOURS_MODULO != 24) begin : g_bad_hours
      $error("settable_clock_core: HOURS_MODULO must be 12 or 24");
   end

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   mode_t           state_q, state_d;
   logic            inc_q, dec_q, mode_q;
   logic            press_inc, press_dec, press_mode;
   logic            tick, adjust;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   blink_q, blink_d;
   logic            phase_q, phase_d;
   logic [5:0]      sec_q, sec_d, min_q, min_d;
   logic [4:0]      hr_q, hr_d;
   logic [2:0]      blank_q, blank_d;
   logic            tick_q;

   assign press_inc  = io.inc_i  & ~inc_q;
   assign press_dec  = io.dec_i  & ~dec_q;
   assign press_mode = io.mode_i & ~mode_q;

   always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
      if (reset_i) state_q <= RUN;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (press_mode) begin
         unique case (state_q)
            RUN:   state_d = SET_H;
            SET_H: state_d = SET_M;
            SET_M: state_d = SET_S;
            SET_S: state_d = RUN;
         endcase
      end
   end

   // A mode press wins over a same-cycle adjust; inc+dec together cancel.
   assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
   assign adjust = (state_q != RUN) && !press_mode && (press_inc ^ press_dec);

   always_comb begin
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      presc_d = (state_q != RUN || press_mode || tick) ? '0 : presc_q + 1'b1;
      if (tick) begin
         if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
               min_d = '0;
               hr_d  = (hr_q == HOUR_LAST) ? '0 : hr_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else if (adjust) begin
         unique case (state_q)
            SET_H: hr_d  = press_inc ? ((hr_q == HOUR_LAST) ? '0 : hr_q + 5'd1)
                                     : ((hr_q == '0) ? HOUR_LAST : hr_q - 5'd1);
            SET_M: min_d = press_inc ? ((min_q == 6'd59) ? '0 : min_q + 6'd1)
                                     : ((min_q == '0) ? 6'd59 : min_q - 6'd1);
            SET_S: sec_d = press_inc ? ((sec_q == 6'd59) ? '0 : sec_q + 6'd1)
                                     : ((sec_q == '0) ? 6'd59 : sec_q - 6'd1);
            default: ;
         endcase
      end
   end

   // Restarting the blink on every edit keeps the edited field visible at once.
   always_comb begin
      blink_d = blink_q + 1'b1;
      phase_d = phase_q;
      if (press_mode || adjust) begin
         blink_d = '0;
         phase_d = 1'b0;
      end else if (blink_q == BLINK_LAST) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end
      unique case (state_d)
         RUN:   blank_d = '0;
         SET_H: blank_d = {phase_d, 2'b00};
         SET_M: blank_d = {1'b0, phase_d, 1'b0};
         SET_S: blank_d = {2'b00, phase_d};
      endcase
   end

   always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
      if (reset_i) begin
         inc_q   <= 1'b1;
         dec_q   <= 1'b1;
         mode_q  <= 1'b1;
         presc_q <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         blank_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         inc_q   <= io.inc_i;
         dec_q   <= io.dec_i;
         mode_q  <= io.mode_i;
         presc_q <= presc_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         blank_q <= blank_d;
         tick_q  <= tick;
      end
   end

   assign io.seconds_o     = sec_q;
   assign io.minutes_o     = min_q;
   assign io.hours_o       = hr_q;
   assign io.mode_o        = state_q;
   assign io.blank_o       = blank_q;
   assign io.second_tick_o = tick_q;

endmodule

// File: tb/tb_settable_clock_core.sv
// Bench for settable_clock_core: directed vector table, corner sequences and
// randomized buttons against a seconds-of-day reference model.
module tb_settable_clock_core;

   localparam int CLK = 10;
   localparam int BLINK_P = 5;

   logic clk;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;

   settable_clock_core_if bus0();
   settable_clock_core_if bus1();

   settable_clock_core #(.CLK_FREQ_HZ(10), .HOURS_MODULO(24), .BLINK_HZ(1)) dut0 (
      .clk_100MHz_i(clk), .reset_i(rst), .io(bus0));
   settable_clock_core #(.CLK_FREQ_HZ(10), .HOURS_MODULO(12), .BLINK_HZ(1)) dut1 (
      .clk_100MHz_i(clk), .reset_i(rst), .io(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit sel;
      bit inc;
      bit dec;
      bit mode;
      int tm;
      int md;
      bit tick;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit sel, bit i, bit d, bit m, int tm, int md, bit t);
      vec_t r;
      r.sel = sel; r.inc = i; r.dec = d; r.mode = m;
      r.tm = tm; r.md = md; r.tick = t;
      return r;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit sel, bit i, bit d, bit m);
      bus0.inc_i = sel ? 1'b0 : i;
      bus0.dec_i = sel ? 1'b0 : d;
      bus0.mode_i = sel ? 1'b0 : m;
      bus1.inc_i = sel ? i : 1'b0;
      bus1.dec_i = sel ? d : 1'b0;
      bus1.mode_i = sel ? m : 1'b0;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   function automatic int rd_time(bit sel);
      if (sel)
         return int'(bus1.hours_o) * 10000 + int'(bus1.minutes_o) * 100 + int'(bus1.seconds_o);
      return int'(bus0.hours_o) * 10000 + int'(bus0.minutes_o) * 100 + int'(bus0.seconds_o);
   endfunction

   // Reference model: time as seconds-of-day, counters as "edges since event".
   int m_t, m_mode, m_run, m_blk;
   bit m_pi, m_pd, m_pm, m_tick;

   task automatic model_reset();
      m_t = 0; m_mode = 0; m_run = 0; m_blk = 0;
      m_pi = 1; m_pd = 1; m_pm = 1; m_tick = 0;
   endtask

   task automatic model_step(bit i, bit d, bit m);
      bit pi, pd, pm, adj;
      int h, mi, s, delta;
      pi = i && !m_pi; pd = d && !m_pd; pm = m && !m_pm;
      m_pi = i; m_pd = d; m_pm = m;
      m_tick = (m_mode == 0) && (m_run % CLK == CLK - 1);
      adj = (m_mode != 0) && !pm && (pi != pd);
      if (m_tick) m_t = (m_t + 1) % 86400;
      if (adj) begin
         h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
         delta = pi ? 1 : -1;
         case (m_mode)
            1: h = (h + delta + 24) % 24;
            2: mi = (mi + delta + 60) % 60;
            default: s = (s + delta + 60) % 60;
         endcase
         m_t = h * 3600 + mi * 60 + s;
      end
      if (m_mode == 0 && !pm) m_run++;
      else m_run = 0;
      if (pm || adj) m_blk = 0;
      else m_blk++;
      if (pm) m_mode = (m_mode + 1) % 4;
   endtask

   function automatic int model_time();
      return (m_t / 3600) * 10000 + ((m_t / 60) % 60) * 100 + (m_t % 60);
   endfunction

   function automatic int model_blank();
      if (m_mode == 0) return 0;
      return ((m_blk / BLINK_P) % 2) << (3 - m_mode);
   endfunction

   initial begin
      int ticks;
      bit b_inc, b_dec, b_mode;
      rst = 1'b1;
      drive(0, 0, 0, 0);

      // Free run after reset: a tick every CLK cycles, 60 in 600 cycles.
      do_reset();
      chk("reset_time", rd_time(0), 0);
      chk("reset_mode", int'(bus0.mode_o), 0);
      chk("reset_blank", int'(bus0.blank_o), 0);
      chk("reset_tick", int'(bus0.second_tick_o), 0);
      ticks = 0;
      for (int k = 1; k <= 600; k++) begin
         cycle();
         if (bus0.second_tick_o) ticks++;
         chk("run_tick", int'(bus0.second_tick_o), (k % CLK == 0) ? 1 : 0);
         chk("run_mode_blank", int'({bus0.mode_o, bus0.blank_o}), 0);
      end
      chk("run_tick_count", ticks, 60);
      chk("run_time", rd_time(0), 100);

      // Vector table: preload, wrap tick, hour decrements, minute corner cases.
      tbl.push_back(v(0,0,0,0, 0,0,0));
      tbl.push_back(v(0,0,0,1, 0,1,0));
      tbl.push_back(v(0,0,0,0, 0,1,0));
      tbl.push_back(v(0,0,1,0, 230000,1,0));
      tbl.push_back(v(0,0,0,0, 230000,1,0));
      tbl.push_back(v(0,0,0,1, 230000,2,0));
      tbl.push_back(v(0,0,0,0, 230000,2,0));
      tbl.push_back(v(0,0,1,0, 235900,2,0));
      tbl.push_back(v(0,0,0,0, 235900,2,0));
      tbl.push_back(v(0,0,0,1, 235900,3,0));
      tbl.push_back(v(0,0,0,0, 235900,3,0));
      tbl.push_back(v(0,0,1,0, 235959,3,0));
      tbl.push_back(v(0,0,0,0, 235959,3,0));
      tbl.push_back(v(0,0,0,1, 235959,0,0));
      for (int k = 0; k < 9; k++) tbl.push_back(v(0,0,0,0, 235959,0,0));
      tbl.push_back(v(0,0,0,0, 0,0,1));
      tbl.push_back(v(0,0,0,0, 0,0,0));
      tbl.push_back(v(0,0,0,1, 0,1,0));
      for (int h = 23; h >= 19; h--) begin
         tbl.push_back(v(0,0,1,0, h * 10000,1,0));
         tbl.push_back(v(0,0,0,0, h * 10000,1,0));
      end
      tbl.push_back(v(0,0,0,1, 190000,2,0));
      tbl.push_back(v(0,0,0,0, 190000,2,0));
      tbl.push_back(v(0,0,1,0, 195900,2,0));
      tbl.push_back(v(0,0,0,0, 195900,2,0));
      tbl.push_back(v(0,0,1,0, 195800,2,0));
      tbl.push_back(v(0,0,0,0, 195800,2,0));
      tbl.push_back(v(0,1,1,0, 195800,2,0));
      tbl.push_back(v(0,0,0,0, 195800,2,0));
      for (int k = 0; k < 50; k++) tbl.push_back(v(0,1,0,0, 195900,2,0));
      tbl.push_back(v(0,0,0,0, 195900,2,0));
      tbl.push_back(v(0,1,0,1, 195900,3,0));
      tbl.push_back(v(0,0,0,0, 195900,3,0));
      // 12-hour instance
      tbl.push_back(v(1,0,0,0, 0,0,0));
      tbl.push_back(v(1,0,0,1, 0,1,0));
      tbl.push_back(v(1,0,1,0, 110000,1,0));
      tbl.push_back(v(1,0,0,0, 110000,1,0));
      tbl.push_back(v(1,0,0,1, 110000,2,0));
      tbl.push_back(v(1,0,1,0, 115900,2,0));
      tbl.push_back(v(1,0,0,0, 115900,2,0));
      tbl.push_back(v(1,0,0,1, 115900,3,0));
      tbl.push_back(v(1,0,1,0, 115959,3,0));
      tbl.push_back(v(1,0,0,0, 115959,3,0));
      tbl.push_back(v(1,0,0,1, 115959,0,0));
      for (int k = 0; k < 9; k++) tbl.push_back(v(1,0,0,0, 115959,0,0));
      tbl.push_back(v(1,0,0,0, 0,0,1));
      tbl.push_back(v(1,0,0,1, 0,1,0));
      tbl.push_back(v(1,0,1,0, 110000,1,0));
      tbl.push_back(v(1,0,0,0, 110000,1,0));
      tbl.push_back(v(1,1,0,0, 0,1,0));
      tbl.push_back(v(1,0,0,0, 0,1,0));

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == 0 || tbl[i].sel != tbl[i-1].sel) do_reset();
         drive(tbl[i].sel, tbl[i].inc, tbl[i].dec, tbl[i].mode);
         cycle();
         chk($sformatf("vec%0d_time", i), rd_time(tbl[i].sel), tbl[i].tm);
         chk($sformatf("vec%0d_mode", i),
             tbl[i].sel ? int'(bus1.mode_o) : int'(bus0.mode_o), tbl[i].md);
         chk($sformatf("vec%0d_tick", i),
             tbl[i].sel ? int'(bus1.second_tick_o) : int'(bus0.second_tick_o),
             int'(tbl[i].tick));
      end

      // SET_H freezes time; hours blank toggles every BLINK_P cycles.
      do_reset();
      drive(0, 0, 0, 0); cycle();
      drive(0, 0, 0, 1); cycle();
      chk("frozen_mode", int'(bus0.mode_o), 1);
      chk("frozen_blank0", int'(bus0.blank_o), 0);
      drive(0, 0, 0, 0);
      for (int k = 1; k <= 100; k++) begin
         cycle();
         chk("frozen_time", rd_time(0), 0);
         chk("frozen_tick", int'(bus0.second_tick_o), 0);
         chk("frozen_blank", int'(bus0.blank_o), ((k / BLINK_P) % 2 == 1) ? 4 : 0);
      end

      // Reset mid SET_S with inc held: immediate clear, no spurious press after.
      do_reset();
      drive(0, 0, 0, 0); cycle();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1); cycle();
         drive(0, 0, 0, 0); cycle();
      end
      chk("sets_mode", int'(bus0.mode_o), 3);
      drive(0, 1, 0, 0); cycle();
      chk("sets_inc", rd_time(0), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_time", rd_time(0), 0);
      chk("async_mode", int'(bus0.mode_o), 0);
      chk("async_blank_tick", int'({bus0.blank_o, bus0.second_tick_o}), 0);
      cycle();
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("post_rst_mode", int'(bus0.mode_o), 0);
         chk("post_rst_time", rd_time(0), 0);
      end
      drive(0, 1, 0, 1); cycle();
      chk("post_rst_seth", int'(bus0.mode_o), 1);
      drive(0, 1, 0, 0); cycle();
      chk("held_no_press", rd_time(0), 0);
      drive(0, 0, 0, 0); cycle();
      chk("released_time", rd_time(0), 0);
      drive(0, 1, 0, 0); cycle();
      chk("repress_time", rd_time(0), 10000);

      // Random button activity against the reference model.
      do_reset();
      model_reset();
      b_inc = 0; b_dec = 0; b_mode = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) b_inc = ~b_inc;
         if ($urandom_range(0, 3) == 0) b_dec = ~b_dec;
         if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
         drive(0, b_inc, b_dec, b_mode);
         model_step(b_inc, b_dec, b_mode);
         cycle();
         chk("rnd_time", rd_time(0), model_time());
         chk("rnd_mode", int'(bus0.mode_o), m_mode);
         chk("rnd_blank", int'(bus0.blank_o), model_blank());
         chk("rnd_tick", int'(bus0.second_tick_o), int'(m_tick));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
